// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead adder.
// State encoding and slice-counter width helper.
package cla_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/carry_lookahead_unit.sv
// W-bit carry-lookahead network: every carry is a flat
// sum-of-products of generate/propagate terms and the carry-in.
module carry_lookahead_unit #(
  parameter int W = 4
) (
  input  logic [W-1:0] g_i,
  input  logic [W-1:0] p_i,
  input  logic         c_i,
  output logic [W-1:0] c_o
);

  logic acc;
  logic pp;

  always_comb begin
    c_o = '0;
    acc = 1'b0;
    pp  = 1'b0;
    for (int i = 0; i < W; i++) begin
      acc = g_i[i];
      pp  = p_i[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g_i[j]);
        pp  = pp & p_i[j];
      end
      acc    = acc | (pp & c_i);
      c_o[i] = acc;
    end
  end

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Multi-cycle N*W-bit adder, one W-bit slice per cycle, LSB first.
// Optional signed-overflow output enabled by CLA_OVF_FLAG_EN.
module cla_seq_adder_ctrl
  import cla_pkg::*;
#(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N*W-1:0] a,
  input  logic [N*W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N*W-1:0] sum,
  output logic         cout
`ifdef CLA_OVF_FLAG_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = cnt_w(N);
  localparam int TW = N * W;

  state_e        state_q;
  logic [TW-1:0] a_q;
  logic [TW-1:0] b_q;
  logic [TW-1:0] sum_q;
  logic [CW-1:0] slice_q;
  logic          carry_q;
  logic          cout_q;
  logic          out_valid_q;

  logic [W-1:0]  a_k;
  logic [W-1:0]  b_k;
  logic [W-1:0]  g;
  logic [W-1:0]  p;
  logic [W-1:0]  c;
  logic [W-1:0]  cin_vec;
  logic [W-1:0]  sum_k;
  logic          msb_cin;
  logic          accept;
  logic          last;

  assign a_k = a_q[int'(slice_q)*W +: W];
  assign b_k = b_q[int'(slice_q)*W +: W];
  assign g   = a_k & b_k;
  assign p   = a_k ^ b_k;

  carry_lookahead_unit #(.W(W)) u_cla (
    .g_i (g),
    .p_i (p),
    .c_i (carry_q),
    .c_o (c)
  );

  // Per-bit carry-in: slice carry for bit 0, lookahead carries above.
  generate
    if (W > 1) begin : g_wide
      assign cin_vec = {c[W-2:0], carry_q};
      assign msb_cin = c[W-2];
    end else begin : g_narrow
      assign cin_vec = carry_q;
      assign msb_cin = carry_q;
    end
  endgenerate

  assign sum_k = p ^ cin_vec;

  assign in_ready = (state_q == S_IDLE) |
                    ((state_q == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign last     = (slice_q == CW'(N - 1));

`ifdef CLA_OVF_FLAG_EN
  logic ovf_q;
  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      slice_q     <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef CLA_OVF_FLAG_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            slice_q <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          sum_q[int'(slice_q)*W +: W] <= sum_k;
          carry_q <= c[W-1];
          if (last) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            cout_q      <= c[W-1];
`ifdef CLA_OVF_FLAG_EN
            ovf_q       <= c[W-1] ^ msb_cin;
`endif
          end else begin
            slice_q <= slice_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (accept) begin
              a_q     <= a;
              b_q     <= b;
              carry_q <= cin;
              slice_q <= '0;
              state_q <= S_RUN;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifndef CLA_OVF_FLAG_EN
  logic unused_msb_cin;
  assign unused_msb_cin = msb_cin;
`endif

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed and random checks of cla_seq_adder_ctrl at W=4,N=4
// and W=8,N=1; ovf checks active when CLA_OVF_FLAG_EN is defined.
module tb_cla_seq_adder_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [15:0] a, b, sum;
  logic        ovf;

  logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1;
  logic [7:0]  a1, b1, sum1;
  logic        ovf1;

  int total = 0;
  int bad   = 0;

  cla_seq_adder_ctrl #(.W(4), .N(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef CLA_OVF_FLAG_EN
    , .ovf(ovf)
`endif
  );

  cla_seq_adder_ctrl #(.W(8), .N(1)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1)
`ifdef CLA_OVF_FLAG_EN
    , .ovf(ovf1)
`endif
  );

`ifndef CLA_OVF_FLAG_EN
  assign ovf  = 1'b0;
  assign ovf1 = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic start4(input logic [15:0] va, input logic [15:0] vb,
                        input logic vc);
    @(negedge clk);
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    chk("in_ready_at_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    a = ~va; b = ~vb; cin = ~vc;
  endtask

  task automatic wait4(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic release4();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("out_valid_after_release", 32'(out_valid), 32'd0);
  endtask

  task automatic op4(input logic [15:0] va, input logic [15:0] vb,
                     input logic vc, input logic [15:0] es,
                     input logic ec, input logic eo);
    int lat;
    start4(va, vb, vc);
    wait4(lat);
    chk("latency_n4", 32'(lat), 32'd5);
    chk("sum_n4", 32'(sum), 32'(es));
    chk("cout_n4", 32'(cout), 32'(ec));
`ifdef CLA_OVF_FLAG_EN
    chk("ovf_n4", 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("unexpected x in ovf vector");
`endif
    release4();
  endtask

  task automatic op1(input logic [7:0] va, input logic [7:0] vb,
                     input logic vc, input logic [7:0] es,
                     input logic ec, input logic eo);
    int lat;
    @(negedge clk);
    a1 = va; b1 = vb; cin1 = vc; in_valid1 = 1'b1;
    chk("in_ready_n1", 32'(in_ready1), 32'd1);
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    a1 = ~va; b1 = ~vb;
    lat = 1;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency_n1", 32'(lat), 32'd2);
    chk("sum_n1", 32'(sum1), 32'(es));
    chk("cout_n1", 32'(cout1), 32'(ec));
`ifdef CLA_OVF_FLAG_EN
    chk("ovf_n1", 32'(ovf1), 32'(eo));
`else
    if (eo === 1'bx) $display("unexpected x in ovf vector");
`endif
    out_ready1 = 1'b1;
    @(posedge clk);
    #1 out_ready1 = 1'b0;
    chk("out_valid_n1_release", 32'(out_valid1), 32'd0);
  endtask

  initial begin
    int lat;
    logic [16:0] r17;
    logic [8:0]  r9;
    logic [15:0] ra, rb;
    logic [7:0]  ra1, rb1;
    logic        rc, ro;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[2] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};

    reset = 1'b1;
    in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0;
    in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      op4(vecs[i].a, vecs[i].b, vecs[i].cin,
          vecs[i].sum, vecs[i].cout, vecs[i].ovf);

    // Backpressure hold for three cycles, then a one-cycle release.
    start4(16'h1234, 16'h4321, 1'b1);
    wait4(lat);
    chk("hold_latency", 32'(lat), 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("hold_sum", 32'(sum), 32'h5556);
      chk("hold_cout", 32'(cout), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    release4();

    // Back-to-back accept straight out of DONE.
    start4(16'hFFFF, 16'h0001, 1'b0);
    wait4(lat);
    chk("b2b_first_sum", 32'(sum), 32'h0000);
    out_ready = 1'b1; in_valid = 1'b1;
    a = 16'h0F0F; b = 16'h00F1; cin = 1'b0;
    #1 chk("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b0; in_valid = 1'b0; a = 16'hAAAA;
    chk("b2b_out_valid_low", 32'(out_valid), 32'd0);
    chk("b2b_running", 32'(in_ready), 32'd0);
    wait4(lat);
    chk("b2b_latency", 32'(lat), 32'd5);
    chk("b2b_sum", 32'(sum), 32'h1000);
    chk("b2b_cout", 32'(cout), 32'd0);
    release4();

    // Asynchronous reset during the second RUN cycle.
    start4(16'h1234, 16'h0001, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
    chk("arst_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("arst_no_partial", 32'(out_valid), 32'd0);
    op4(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    op1(8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      r17 = {1'b0, ra} + {1'b0, rb} + 17'(rc);
      ro = (ra[15] == rb[15]) && (r17[15] != ra[15]);
      op4(ra, rb, rc, r17[15:0], r17[16], ro);
    end
    for (int i = 0; i < 2000; i++) begin
      ra1 = 8'($urandom); rb1 = 8'($urandom); rc = 1'($urandom);
      r9 = {1'b0, ra1} + {1'b0, rb1} + 9'(rc);
      ro = (ra1[7] == rb1[7]) && (r9[7] != ra1[7]);
      op1(ra1, rb1, rc, r9[7:0], r9[8], ro);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
